// File: rtl/paddle_input_ctrl.sv
// paddle_input_ctrl
//
// Conditions the two raw active-low paddle buttons and owns the paddle's
// horizontal centre position for the breakout display path.
//   - each button: two-flop synchroniser (stored inverted, 1 = pressed),
//     then a stability-counter debouncer
//   - on each frame_tick: resolve direction from the debounced levels,
//     step slowly for ACCEL_FRAMES frames, then fast, clamped to the walls
//
// Ports:
//   clock      in   pixel clock, the only clock
//   reset      in   asynchronous, active-high
//   left       in   raw left button, active-low, asynchronous to clock
//   right      in   raw right button, active-low, asynchronous to clock
//   frame_tick in   single-cycle pulse, one per frame
//   paddle_x   out  [9:0] registered paddle centre x
//   moving     out  registered; 1 if the most recent frame_tick moved the paddle
//   left_db    out  debounced left level, 1 = pressed
//   right_db   out  debounced right level, 1 = pressed
module paddle_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int PX_RESET        = 320,
  parameter int PX_MIN          = 24,
  parameter int PX_MAX          = 616,
  parameter int STEP_SLOW       = 1,
  parameter int STEP_FAST       = 3,
  parameter int ACCEL_FRAMES    = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       left,
  input  logic       right,
  input  logic       frame_tick,
  output logic [9:0] paddle_x,
  output logic       moving,
  output logic       left_db,
  output logic       right_db
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = (ACCEL_FRAMES < 1) ? 1 : $clog2(ACCEL_FRAMES + 1);

  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(ACCEL_FRAMES);
  localparam logic [10:0]       PX_MIN_W  = 11'(PX_MIN);
  localparam logic [10:0]       PX_MAX_W  = 11'(PX_MAX);
  localparam logic [10:0]       STEP_S_W  = 11'(STEP_SLOW);
  localparam logic [10:0]       STEP_F_W  = 11'(STEP_FAST);

  typedef enum logic [1:0] {
    DIR_NONE  = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_RIGHT = 2'd2
  } dir_t;

  // Index 0 = left button, index 1 = right button.
  logic [1:0]       btn_pressed;
  logic [1:0]       sync1_q, sync1_d;
  logic [1:0]       sync2_q, sync2_d;
  logic [1:0]       db_q, db_d;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];

  logic [9:0]        paddle_x_q, paddle_x_d;
  logic              moving_q, moving_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  dir_t              last_dir_q, last_dir_d;

  dir_t        dir;
  logic [10:0] step;
  logic [10:0] x_old;
  logic [10:0] x_new;
  logic [10:0] x_sum;

  // Invert at the pin so that the reset value 0 means "released".
  assign btn_pressed = {~right, ~left};

  // ---------------------------------------------------------------------
  // Synchroniser and debounce
  // ---------------------------------------------------------------------
  always_comb begin
    sync1_d = btn_pressed;
    sync2_d = sync1_q;
    db_d    = db_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        // Held different for the full window: accept the new level.
        db_d[i]  = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_q     <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      db_q     <= db_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
    end
  end

  // ---------------------------------------------------------------------
  // Direction, acceleration and position
  // ---------------------------------------------------------------------
  always_comb begin
    dir = DIR_NONE;
    if (db_q[0] && !db_q[1]) begin
      dir = DIR_LEFT;
    end else if (db_q[1] && !db_q[0]) begin
      dir = DIR_RIGHT;
    end

    // Fast step only once the same direction has been held for
    // ACCEL_FRAMES frames (hold value before this frame's update).
    step = STEP_S_W;
    if (dir == last_dir_q && dir != DIR_NONE && hold_q >= HOLD_MAX) begin
      step = STEP_F_W;
    end

    // 11-bit unsigned arithmetic; compare before subtracting so the left
    // wall never wraps.
    x_old = {1'b0, paddle_x_q};
    x_sum = x_old + step;
    x_new = x_old;
    case (dir)
      DIR_LEFT:  x_new = (x_old < PX_MIN_W + step) ? PX_MIN_W : (x_old - step);
      DIR_RIGHT: x_new = (x_sum > PX_MAX_W) ? PX_MAX_W : x_sum;
      default:   x_new = x_old;
    endcase

    paddle_x_d = paddle_x_q;
    moving_d   = moving_q;
    hold_d     = hold_q;
    last_dir_d = last_dir_q;
    if (frame_tick) begin
      paddle_x_d = x_new[9:0];
      moving_d   = (x_new != x_old);
      last_dir_d = dir;
      if (dir == DIR_NONE) begin
        hold_d = '0;
      end else if (dir != last_dir_q) begin
        hold_d = HOLD_W'(1);
      end else if (hold_q < HOLD_MAX) begin
        hold_d = hold_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      paddle_x_q <= 10'(PX_RESET);
      moving_q   <= 1'b0;
      hold_q     <= '0;
      last_dir_q <= DIR_NONE;
    end else begin
      paddle_x_q <= paddle_x_d;
      moving_q   <= moving_d;
      hold_q     <= hold_d;
      last_dir_q <= last_dir_d;
    end
  end

  assign paddle_x = paddle_x_q;
  assign moving   = moving_q;
  assign left_db  = db_q[0];
  assign right_db = db_q[1];

endmodule

// File: tb/tb_paddle_input_ctrl.sv
// Testbench for paddle_input_ctrl with DEBOUNCE_CYCLES = 4, other
// parameters at default. Expected paddle position/moving per frame tick
// come from a behavioural model (run length of the current direction)
// and travel through exp_q until the DUT has processed the tick.
module tb_paddle_input_ctrl;

  localparam int DB      = 4;
  localparam int PX_RST  = 320;
  localparam int PX_LO   = 24;
  localparam int PX_HI   = 616;
  localparam int N_SLOW  = 8;

  logic       clock;
  logic       reset;
  logic       left;
  logic       right;
  logic       frame_tick;
  logic [9:0] paddle_x;
  logic       moving;
  logic       left_db;
  logic       right_db;

  int total = 0;
  int bad   = 0;

  // {moving, paddle_x}
  logic [10:0] exp_q[$];

  // Model state: debounced levels the bench has settled, position,
  // direction of the current run and its length in frames.
  bit m_l, m_r;
  int m_x;
  int m_dir;   // 0 none, 1 left, 2 right
  int m_run;
  bit m_mov;

  paddle_input_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
    .clock      (clock),
    .reset      (reset),
    .left       (left),
    .right      (right),
    .frame_tick (frame_tick),
    .paddle_x   (paddle_x),
    .moving     (moving),
    .left_db    (left_db),
    .right_db   (right_db)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  task automatic model_reset();
    m_x = PX_RST; m_dir = 0; m_run = 0; m_mov = 0;
  endtask

  task automatic model_tick();
    int d, step, nx;
    d = (m_l && !m_r) ? 1 : (m_r && !m_l) ? 2 : 0;
    nx = m_x;
    if (d == 0) begin
      m_run = 0;
    end else begin
      m_run = (d == m_dir) ? m_run + 1 : 1;
      step = (m_run > N_SLOW) ? 3 : 1;
      if (d == 1) nx = (m_x - step < PX_LO) ? PX_LO : m_x - step;
      else        nx = (m_x + step > PX_HI) ? PX_HI : m_x + step;
    end
    m_mov = (nx != m_x);
    m_x   = nx;
    m_dir = d;
  endtask

  // ---------------- drivers ----------------
  task automatic set_buttons(input bit lp, input bit rp);
    @(negedge clock);
    left  = ~lp;
    right = ~rp;
    repeat (DB + 6) @(negedge clock);
    chk("left_db_settle", left_db, lp);
    chk("right_db_settle", right_db, rp);
    m_l = lp;
    m_r = rp;
  endtask

  task automatic do_tick(input string tag);
    logic [10:0] e;
    model_tick();
    exp_q.push_back({m_mov, 10'(m_x)});
    @(negedge clock);
    frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_x"}, paddle_x, e[9:0]);
      chk({tag, "_moving"}, moving, e[10]);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    reset = 1'b0; left = 1'b1; right = 1'b1; frame_tick = 1'b0;
    m_l = 0; m_r = 0;
    model_reset();

    // 1. asynchronous reset mid-cycle
    #13 reset = 1'b1;
    #1;
    chk("rst_async_x", paddle_x, PX_RST);
    chk("rst_async_moving", moving, 0);
    chk("rst_async_left_db", left_db, 0);
    chk("rst_async_right_db", right_db, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    do_tick("idle_tick");

    // 2. bounce rejection on right, then stable press
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      right = ~right;
      @(negedge clock); chk("bounce_right_db", right_db, 0);
      @(negedge clock); chk("bounce_right_db", right_db, 0);
    end
    @(negedge clock);
    right = 1'b0;
    repeat (6) @(posedge clock);
    #1 chk("db_before_6", right_db, 0);
    @(posedge clock);
    #1 chk("db_at_6", right_db, 1);
    m_r = 1;

    // 3. acceleration: 8 slow then fast
    for (int i = 0; i < 12; i++) do_tick("accel");
    chk("accel_end_x", paddle_x, 340);

    // 4. both pressed, then right restart, then reversal
    set_buttons(1, 1);
    for (int i = 0; i < 3; i++) do_tick("both");
    set_buttons(0, 1);
    do_tick("right_restart");
    chk("right_restart_x", paddle_x, 341);
    for (int i = 0; i < 9; i++) do_tick("right_run");
    set_buttons(1, 0);
    do_tick("reverse");
    chk("reverse_x", paddle_x, 353);

    // 5. clamp at left wall, then at right wall
    guard = 0;
    while (m_x != PX_LO && guard < 400) begin
      do_tick("to_left_wall");
      guard++;
    end
    for (int i = 0; i < 2; i++) do_tick("pinned_left");
    chk("pinned_left_x", paddle_x, PX_LO);
    set_buttons(0, 1);
    guard = 0;
    while (m_x != PX_HI && guard < 400) begin
      do_tick("to_right_wall");
      guard++;
    end
    for (int i = 0; i < 2; i++) do_tick("pinned_right");
    chk("pinned_right_x", paddle_x, PX_HI);

    // 6. reset during the fast phase
    set_buttons(1, 0);
    for (int i = 0; i < 10; i++) do_tick("fast_left");
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    chk("rst_mid_x", paddle_x, PX_RST);
    chk("rst_mid_moving", moving, 0);
    chk("rst_mid_left_db", left_db, 0);
    chk("rst_mid_right_db", right_db, 0);
    left = 1'b1;
    right = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_reset();
    m_l = 0; m_r = 0;
    repeat (DB + 6) @(negedge clock);
    chk("post_rst_right_db", right_db, 1);
    m_r = 1;
    do_tick("post_rst_first");
    chk("post_rst_first_x", paddle_x, PX_RST + 1);

    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
